// File: rtl/pair_filter.sv
// pair_filter: three-stage neighbor distance filter with cutoff test
// feeding a first-word-fall-through pair FIFO.
module pair_filter #(
    parameter int unsigned FIFO_DEPTH = 16,
    parameter logic [67:0] CUTOFF2    = 68'h0_0000_0001_0000_0000
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         flush,
    input  logic [113:0] reference,
    input  logic [113:0] neighbor,
    input  logic         pair_ready,
    output logic         pair_valid,
    output logic [181:0] pair_data,
    output logic [31:0]  pair_count,
    output logic [15:0]  drop_count,
    output logic         overflow,
    output logic         busy
);

    localparam int AW = $clog2(FIFO_DEPTH);

    function automatic logic [32:0] diff(
        input logic [31:0] a,
        input logic [31:0] b
    );
        return {a[31], a} - {b[31], b};
    endfunction

    function automatic logic [65:0] square(
        input logic [32:0] d
    );
        logic signed [65:0] e;
        e = {{33{d[32]}}, d};
        return e * e;
    endfunction

    // held reference: identity {addr, cell} and packed coordinates
    logic        ref_vld;
    logic [16:0] ref_id;
    logic [95:0] ref_xyz;

    logic        nbr_null;
    logic        ref_null;
    logic [16:0] nbr_id;

    assign ref_null = reference[96];
    assign nbr_null = neighbor[96];
    assign nbr_id   = neighbor[113:97];

    // S1: coordinate differences
    logic        s1_vld;
    logic        s1_same;
    logic [8:0]  s1_ra;
    logic [8:0]  s1_na;
    logic [32:0] s1_dx;
    logic [32:0] s1_dy;
    logic [32:0] s1_dz;

    // S2: squares
    logic        s2_vld;
    logic        s2_same;
    logic [8:0]  s2_ra;
    logic [8:0]  s2_na;
    logic [31:0] s2_dx;
    logic [31:0] s2_dy;
    logic [31:0] s2_dz;
    logic [65:0] s2_sqx;
    logic [65:0] s2_sqy;
    logic [65:0] s2_sqz;

    // S3: squared distance
    logic        s3_vld;
    logic        s3_same;
    logic [8:0]  s3_ra;
    logic [8:0]  s3_na;
    logic [31:0] s3_dx;
    logic [31:0] s3_dy;
    logic [31:0] s3_dz;
    logic [67:0] s3_r2;

    logic         accept;
    logic [181:0] s3_word;

    // FIFO
    logic [181:0] mem [FIFO_DEPTH];
    logic [AW:0]  wr_ptr;
    logic [AW:0]  rd_ptr;
    logic         empty;
    logic         full;
    logic         pop;
    logic         wr_en;
    logic         drop;

    always_ff @(posedge clk) begin
        if (!ref_null) begin
            ref_id  <= reference[113:97];
            ref_xyz <= reference[95:0];
        end
    end

    always_ff @(posedge clk) begin
        s1_same <= (ref_id == nbr_id);
        s1_ra   <= ref_id[16:8];
        s1_na   <= nbr_id[16:8];
        s1_dx   <= diff(ref_xyz[31:0],  neighbor[31:0]);
        s1_dy   <= diff(ref_xyz[63:32], neighbor[63:32]);
        s1_dz   <= diff(ref_xyz[95:64], neighbor[95:64]);
    end

    // an accepted pair has |d| < sqrt(CUTOFF2), so 32-bit deltas are exact
    // for any cutoff up to 2^62; the squares still use the full 33 bits
    always_ff @(posedge clk) begin
        s2_same <= s1_same;
        s2_ra   <= s1_ra;
        s2_na   <= s1_na;
        s2_dx   <= s1_dx[31:0];
        s2_dy   <= s1_dy[31:0];
        s2_dz   <= s1_dz[31:0];
        s2_sqx  <= square(s1_dx);
        s2_sqy  <= square(s1_dy);
        s2_sqz  <= square(s1_dz);
    end

    always_ff @(posedge clk) begin
        s3_same <= s2_same;
        s3_ra   <= s2_ra;
        s3_na   <= s2_na;
        s3_dx   <= s2_dx;
        s3_dy   <= s2_dy;
        s3_dz   <= s2_dz;
        s3_r2   <= {2'b00, s2_sqx} + {2'b00, s2_sqy} + {2'b00, s2_sqz};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ref_vld <= 1'b0;
            s1_vld  <= 1'b0;
            s2_vld  <= 1'b0;
            s3_vld  <= 1'b0;
        end else if (flush) begin
            ref_vld <= 1'b0;
            s1_vld  <= 1'b0;
            s2_vld  <= 1'b0;
            s3_vld  <= 1'b0;
        end else begin
            if (!ref_null) begin
                ref_vld <= 1'b1;
            end
            s1_vld <= ref_vld && !nbr_null;
            s2_vld <= s1_vld;
            s3_vld <= s2_vld;
        end
    end

    assign accept = s3_vld
                 && (s3_r2 != 68'd0)
                 && (s3_r2 < CUTOFF2)
                 && !s3_same;

    assign s3_word = {s3_ra, s3_na, s3_dz, s3_dy, s3_dx, s3_r2};

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW])
                && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

    assign pair_valid = !empty;
    assign pop        = pair_valid && pair_ready;
    assign wr_en      = accept && !flush && (!full || pop);
    assign drop       = accept && !flush && full && !pop;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr[AW-1:0]] <= s3_word;
        end
    end

    // empty FIFO presents zeros, which covers the reset case
    assign pair_data = empty ? '0 : mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            pair_count <= '0;
        end else if (flush) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            pair_count <= '0;
        end else begin
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (wr_en) begin
                wr_ptr     <= wr_ptr + 1'b1;
                pair_count <= pair_count + 32'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            drop_count <= '0;
            overflow   <= 1'b0;
        end else if (drop) begin
            overflow <= 1'b1;
            if (drop_count != 16'hFFFF) begin
                drop_count <= drop_count + 16'd1;
            end
        end
    end

    assign busy = s1_vld || s2_vld || s3_vld;

endmodule
